// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file: the write-operation type and its encodings.
package reg_file_pkg;

    typedef logic [1:0] wr_op_t;

    localparam wr_op_t OP_HOLD = 2'b00;
    localparam wr_op_t OP_LOAD = 2'b01;
    localparam wr_op_t OP_INC  = 2'b10;
    localparam wr_op_t OP_CLR  = 2'b11;

endpackage : reg_file_pkg

// File: rtl/reg_cell_nbit.sv
// One register of the file: WIDTH-bit data plus a valid bit, with local op decode.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   sel_i       - this cell is the write target this cycle
//   op_i        - write operation (HOLD/LOAD/INC/CLR)
//   din_i       - load data
//   q_o         - stored data
//   valid_o     - written (LOAD/INC) since last reset/CLR
//   wrap_c      - combinational: an INC this cycle will wrap all-ones to zero
module reg_cell_nbit
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel_i,
    input  wr_op_t           op_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o,
    output logic             wrap_c
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;

    // Next-state decode; an unselected cell or HOLD keeps its contents.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        if (sel_i) begin
            case (op_i)
                OP_LOAD: begin
                    q_d     = din_i;
                    valid_d = 1'b1;
                end
                OP_INC: begin
                    q_d     = q_q + WIDTH'(1);
                    valid_d = 1'b1;
                end
                OP_CLR: begin
                    q_d     = '0;
                    valid_d = 1'b0;
                end
                default: begin
                    q_d     = q_q;
                    valid_d = valid_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign wrap_c  = sel_i && (op_i == OP_INC) && (&q_q);
    assign q_o     = q_q;
    assign valid_o = valid_q;

endmodule : reg_cell_nbit

// File: rtl/reg_file_nbit.sv
// DEPTH x WIDTH register file with one write port (LOAD/INC/CLR/HOLD), two
// combinational read ports with per-register valid flags, and a registered
// one-cycle overflow pulse for wrapping increments.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   wr_addr, wr_op, Din   - write target, operation and load data
//   rd_addr_a, rd_addr_b  - read addresses
//   Dout_a, Dout_b        - read data (stored state, no write bypass)
//   valid_a, valid_b      - valid flag of the addressed register
//   ovf                   - high for the cycle after an INC wrapped
module reg_file_nbit
    import reg_file_pkg::*;
#(
    parameter  int unsigned WIDTH = 5,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    wr_addr,
    input  wr_op_t           wr_op,
    input  logic [WIDTH-1:0] Din,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] Dout_a,
    output logic [WIDTH-1:0] Dout_b,
    output logic             valid_a,
    output logic             valid_b,
    output logic             ovf
);

    logic [WIDTH-1:0] cell_q     [DEPTH];
    logic [DEPTH-1:0] cell_valid;
    logic [DEPTH-1:0] cell_wrap;
    logic             ovf_q, ovf_d;

    // One cell per address; only the addressed cell sees the write.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_cell_nbit #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .sel_i   (wr_addr == AW'(g)),
            .op_i    (wr_op),
            .din_i   (Din),
            .q_o     (cell_q[g]),
            .valid_o (cell_valid[g]),
            .wrap_c  (cell_wrap[g])
        );
    end

    // At most one cell is selected, so OR-reducing the wrap flags is exact.
    assign ovf_d = |cell_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Dout_a  = cell_q[rd_addr_a];
    assign Dout_b  = cell_q[rd_addr_b];
    assign valid_a = cell_valid[rd_addr_a];
    assign valid_b = cell_valid[rd_addr_b];
    assign ovf     = ovf_q;

endmodule : reg_file_nbit

// File: doc/reg_file_nbit.md
REG_FILE_NBIT -- requirements
Module: reg_file_nbit

Interface
REQ-001 Parameter WIDTH, default 5, data width of each register; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of registers; SHALL be a power of 2, >= 2.
REQ-003 Derived constant AW = clog2(DEPTH), address width; SHALL NOT be overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_addr  input  AW  target register of the write operation.
REQ-007 wr_op  input  2  write operation: 00 HOLD, 01 LOAD, 10 INC, 11 CLR.
REQ-008 Din  input  WIDTH  load data, used only when wr_op = LOAD.
REQ-009 rd_addr_a  input  AW  read port A address.
REQ-010 rd_addr_b  input  AW  read port B address.
REQ-011 Dout_a  output  WIDTH  contents of register rd_addr_a.
REQ-012 Dout_b  output  WIDTH  contents of register rd_addr_b.
REQ-013 valid_a  output  1  register rd_addr_a written (LOAD/INC) since last reset/CLR.
REQ-014 valid_b  output  1  same as valid_a, for rd_addr_b.
REQ-015 ovf  output  1  registered one-cycle pulse: previous-cycle INC wrapped.

Function
REQ-016 HOLD: no register, valid bit or ovf source SHALL change; ovf SHALL be 0 the following cycle.
REQ-017 LOAD: reg[wr_addr] <= Din, valid[wr_addr] <= 1 at the rising edge.
REQ-018 INC: reg[wr_addr] <= (reg[wr_addr] + 1) mod 2^WIDTH, valid[wr_addr] <= 1.
REQ-019 INC when reg[wr_addr] is all ones: result 0; ovf SHALL be 1 for exactly the next cycle.
REQ-020 INC of an invalid (cleared) register SHALL start from its stored value 0, giving 1.
REQ-021 CLR: reg[wr_addr] <= 0, valid[wr_addr] <= 0.
REQ-022 Only register wr_addr SHALL be affected; all others SHALL hold.
REQ-023 Reads SHALL be combinational from stored state; no write-to-read bypass. During a write cycle, Dout/valid show pre-edge contents and update after the edge.
REQ-024 Both read ports SHALL be independent; equal addresses SHALL give identical outputs.
REQ-025 ovf SHALL be 0 in any cycle not immediately following a wrapping INC; back-to-back wrapping INCs to different registers SHALL hold ovf high for consecutive cycles.
REQ-026 Read-only operation with wr_op = HOLD SHALL have zero state side effects.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, set all registers to 0, all valid bits to 0, and ovf to 0.
REQ-028 Therefore Dout_a = Dout_b = 0 and valid_a = valid_b = 0 during reset.
REQ-029 wr_op SHALL be ignored while reset is high; a write in the edge coinciding with reset SHALL be lost.
REQ-030 After reset deasserts, the first rising edge SHALL execute wr_op normally.

Structure
REQ-031 Shared package reg_file_pkg SHALL hold the wr_op encodings (OP_HOLD, OP_LOAD, OP_INC, OP_CLR) and the 2-bit op type.
REQ-032 Sub-module reg_cell_nbit (one WIDTH-bit register plus valid bit, op decode, wrap detect, async reset) SHALL be instantiated DEPTH times via generate; the top SHALL hold the address decode, the read muxes and the ovf register.

Verification (WIDTH=5, DEPTH=4)
REQ-033 Reset, then read all addresses -> Dout = 0, valid = 0, ovf = 0.
REQ-034 LOAD r2 = 5'h13 -> same-cycle Dout_a(rd=2) = 0; next cycle Dout_a = 5'h13, valid_a = 1; r0/r1/r3 unchanged.
REQ-035 LOAD r1 = 5'h1F, then INC r1 -> r1 = 0, valid = 1, ovf = 1 for one cycle only; HOLD -> ovf = 0.
REQ-036 CLR r1 (holding 7), then INC r1 -> after CLR r1 = 0, valid = 0; after INC r1 = 1, valid = 1, ovf = 0.
REQ-037 rd_addr_a = rd_addr_b = 3 after LOAD r3 = 5'h0A -> both ports show 5'h0A, valid 1.
REQ-038 Assert reset mid-sequence between edges with r0 = 5'h05 -> Dout = 0 and ovf = 0 immediately; LOAD issued on the edge under reset is lost.
